// File: rtl/pipe_issue_ctrl_pkg.sv
// Shared state encodings and width helpers for the pipelined issue controller.
package pipe_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    // Bits needed to hold values 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/pipe_result_fifo.sv
// Result FIFO: synchronous, any depth, pointers wrap modulo DEPTH; clear beats push/pop.
// Latency: a push is visible at the head on the following cycle.
// Backpressure: none; pop ignored when empty, push at full only legal alongside a pop.
module pipe_result_fifo
    import pipe_issue_ctrl_pkg::*;
#(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int CNT_W = cnt_w(DEPTH + 1)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic [CNT_W-1:0] o_count
);
    localparam int PTR_W = cnt_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             pop_ok;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign pop_ok = i_pop && (o_count != '0);
    assign o_head = (o_count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            o_count <= '0;
        end else begin
            if (i_push) begin
                mem[wr_ptr] <= i_push_data;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok)
                rd_ptr <= ptr_inc(rd_ptr);
            if (i_push && !pop_ok)
                o_count <= o_count + CNT_W'(1);
            else if (!i_push && pop_ok)
                o_count <= o_count - CNT_W'(1);
        end
    end

    // The credit rule upstream makes an unpaired push at full unreachable.
    always_ff @(posedge i_clk) begin
        if (!i_rst && !i_clr)
            assert (!(i_push && !pop_ok && (o_count == CNT_W'(DEPTH))));
    end

endmodule

// File: rtl/pipe_issue_ctrl.sv
// Issue/return controller for a fixed-latency datapath; optional counters under PIPE_ISSUE_CTRL_STATS_EN.
// Latency: launch in the accept cycle; result on o_valid LATENCY+1 cycles later when the FIFO is empty.
// Backpressure: o_ready drops while in-flight plus queued results would reach FIFO_DEPTH.
module pipe_issue_ctrl
    import pipe_issue_ctrl_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_dp_en,
    output logic [WIDTH-1:0] o_dp_data,
    input  logic [WIDTH-1:0] i_dp_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    input  logic             i_flush,
    output logic             o_busy
`ifdef PIPE_ISSUE_CTRL_STATS_EN
    ,
    output logic [31:0]      o_issue_cnt,
    output logic [31:0]      o_stall_cnt
`endif
);
    localparam int CNT_W = cnt_w(FIFO_DEPTH + 1);
    localparam int FC_W  = cnt_w(LATENCY + 1);
    localparam int IF_W  = cnt_w(LATENCY + 1);
    localparam int SUM_W = cnt_w(LATENCY + FIFO_DEPTH + 1);

    state_t             state;
    logic [LATENCY-1:0] vld_sr;
    logic [FC_W-1:0]    flush_cnt;
    logic [IF_W-1:0]    inflight;
    logic [CNT_W-1:0]   fifo_cnt;
    logic               accept;
    logic               push;
    logic               fifo_clr;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < LATENCY; i++)
            inflight = inflight + IF_W'(vld_sr[i]);
    end

    // A pop this cycle is not counted: its slot is only reusable next cycle.
    assign o_ready   = !i_rst && !i_flush && (state != ST_FLUSH) &&
                       ((SUM_W'(inflight) + SUM_W'(fifo_cnt)) < SUM_W'(FIFO_DEPTH));
    assign accept    = i_valid && o_ready;
    assign o_dp_en   = accept;
    assign o_dp_data = i_data;
    assign o_busy    = (state != ST_IDLE);
    assign o_valid   = (fifo_cnt != '0);
    assign fifo_clr  = i_flush || (state == ST_FLUSH);
    assign push      = vld_sr[LATENCY-1] && !fifo_clr;

    pipe_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_clr       (fifo_clr),
        .i_push      (push),
        .i_push_data (i_dp_data),
        .i_pop       (o_valid && i_ready),
        .o_head      (o_data),
        .o_count     (fifo_cnt)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            vld_sr    <= '0;
            flush_cnt <= '0;
        end else if (i_flush) begin
            state     <= ST_FLUSH;
            vld_sr    <= '0;
            flush_cnt <= FC_W'(LATENCY);
        end else begin
            case (state)
                ST_IDLE: begin
                    vld_sr <= (vld_sr << 1) | LATENCY'(accept);
                    if (accept)
                        state <= ST_BUSY;
                end
                ST_BUSY: begin
                    vld_sr <= (vld_sr << 1) | LATENCY'(accept);
                    if ((inflight == '0) && (fifo_cnt == '0) && !accept)
                        state <= ST_IDLE;
                end
                ST_FLUSH: begin
                    // Stale datapath outputs drain unobserved while the counter runs.
                    vld_sr <= '0;
                    if (flush_cnt <= FC_W'(1)) begin
                        state     <= ST_IDLE;
                        flush_cnt <= '0;
                    end else begin
                        flush_cnt <= flush_cnt - FC_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PIPE_ISSUE_CTRL_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_issue_cnt <= '0;
            o_stall_cnt <= '0;
        end else begin
            if (accept)
                o_issue_cnt <= o_issue_cnt + 32'd1;
            if (o_valid && !i_ready)
                o_stall_cnt <= o_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_issue_ctrl.sv
// Bench for pipe_issue_ctrl: transaction-level model checked every cycle plus directed scenarios.
module tb_pipe_issue_ctrl;
    localparam int LAT = 4;
    localparam int DEP = 4;

    typedef struct {
        int         due;
        logic [7:0] val;
    } pend_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       i_valid = 1'b0;
    logic       i_ready = 1'b0;
    logic       i_flush = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic [7:0] dp_in;
    logic       o_ready, o_dp_en, o_valid, o_busy;
    logic [7:0] o_dp_data, o_data;
    logic [7:0] dp_pipe [LAT];
`ifdef PIPE_ISSUE_CTRL_STATS_EN
    logic [31:0] issue_cnt, stall_cnt;
`endif

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    pend_t      pend_q[$];
    logic [7:0] res_q[$];
    logic [7:0] got_q[$];
    int         flush_left = 0;
    bit         m_busy = 1'b0;
    bit         m_ready, m_accept, nxt_busy;
    pend_t      tmp;

    pipe_issue_ctrl #(.LATENCY(LAT), .WIDTH(8), .FIFO_DEPTH(DEP)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_data    (i_data),
        .o_dp_en   (o_dp_en),
        .o_dp_data (o_dp_data),
        .i_dp_data (dp_in),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_data    (o_data),
        .i_flush   (i_flush),
        .o_busy    (o_busy)
`ifdef PIPE_ISSUE_CTRL_STATS_EN
        ,
        .o_issue_cnt (issue_cnt),
        .o_stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Free-running 4-stage datapath computing x+1.
    always @(posedge clk) begin
        dp_pipe[0] <= o_dp_data + 8'd1;
        for (int i = 1; i < LAT; i++)
            dp_pipe[i] <= dp_pipe[i-1];
    end
    assign dp_in = dp_pipe[LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int k = 0;
        i_valid = 1'b1;
        i_data  = d;
        @(negedge clk);
        while (!o_ready && k < 40) begin
            tick();
            @(negedge clk);
            k++;
        end
        chk("send_wait", 32'(k < 40), 32'd1);
        tick();
    endtask

    task automatic wait_results(input int n, input string nm);
        int k = 0;
        while (got_q.size() < n && k < 60) begin
            tick();
            k++;
        end
        chk(nm, got_q.size(), n);
    endtask

    // Model: ops are pending for LATENCY cycles, then queue; credits count both.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                chk("m_ready_in_reset", o_ready, 0);
                pend_q.delete();
                res_q.delete();
                flush_left = 0;
                m_busy = 1'b0;
                continue;
            end
            m_ready  = !i_flush && (flush_left == 0) && (pend_q.size() + res_q.size() < DEP);
            m_accept = i_valid && m_ready;
            chk("m_ready", o_ready, m_ready);
            chk("m_dp_en", o_dp_en, m_accept);
            if (m_accept)
                chk("m_dp_data", o_dp_data, i_data);
            chk("m_valid", o_valid, res_q.size() != 0);
            if (res_q.size() != 0)
                chk("m_data", o_data, res_q[0]);
            chk("m_busy", o_busy, m_busy);
            if (o_valid && i_ready)
                got_q.push_back(o_data);

            nxt_busy = m_accept || pend_q.size() != 0 || res_q.size() != 0;
            if (i_flush) begin
                pend_q.delete();
                res_q.delete();
                flush_left = LAT;
                nxt_busy = 1'b1;
            end else if (flush_left > 0) begin
                flush_left--;
                nxt_busy = flush_left > 0;
            end else begin
                if (res_q.size() != 0 && i_ready)
                    void'(res_q.pop_front());
                while (pend_q.size() != 0 && pend_q[0].due == cyc) begin
                    tmp = pend_q.pop_front();
                    res_q.push_back(tmp.val);
                end
                if (m_accept)
                    pend_q.push_back('{cyc + LAT, i_data + 8'd1});
            end
            m_busy = nxt_busy;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  base;
        int  acc;
        int  n;
        bit  last_rdy;

        repeat (2) tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", o_ready, 1);
        chk("rst_valid", o_valid, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_data", o_data, 0);
        tick();

        // 1: single op, result on cycle 5.
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h10;
        @(negedge clk);
        chk("t1_dp_en", o_dp_en, 1);
        chk("t1_dp_data", o_dp_data, 8'h10);
        tick();
        i_valid = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("t1_valid_c4", o_valid, 0);
        tick();
        @(negedge clk);
        chk("t1_valid_c5", o_valid, 1);
        chk("t1_data_c5", o_data, 8'h11);
        repeat (3) tick();
        @(negedge clk);
        chk("t1_busy_after", o_busy, 0);
        tick();

        // 2: sixteen ops offered back to back.
        base = got_q.size();
        for (int v = 0; v < 16; v++)
            send(8'(v));
        i_valid = 1'b0;
        wait_results(base + 16, "t2_count");
        for (int i = 0; i < 16; i++)
            chk("t2_order", got_q[base + i], 32'(i + 1));
        repeat (3) tick();

        // 3: downstream stalled, requester always valid.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = 8'h20;
        acc = 0;
        last_rdy = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            last_rdy = o_ready;
            if (last_rdy) acc++;
            tick();
            if (last_rdy) i_data = i_data + 8'd1;
        end
        i_valid = 1'b0;
        chk("t3_accepts", acc, 4);
        chk("t3_ready_low", last_rdy, 0);
        base = got_q.size();
        i_ready = 1'b1;
        wait_results(base + 4, "t3_drain");
        for (int i = 0; i < 4; i++)
            chk("t3_order", got_q[base + i], 32'(8'h21 + i));
        repeat (6) tick();
        chk("t3_no_dup", got_q.size(), base + 4);

        // 4: last result lands while the head pops.
        i_ready = 1'b0;
        base = got_q.size();
        send(8'h30); send(8'h31); send(8'h32); send(8'h33);
        i_valid = 1'b0;
        repeat (3) tick();
        i_ready = 1'b1;
        @(negedge clk);
        chk("t4_valid", o_valid, 1);
        chk("t4_ready_no_credit", o_ready, 0);
        wait_results(base + 4, "t4_count");
        for (int i = 0; i < 4; i++)
            chk("t4_order", got_q[base + i], 32'(8'h31 + i));
        repeat (3) tick();

        // 5: flush with 2 queued and 2 in flight, concurrent accept attempt.
        i_ready = 1'b0;
        base = got_q.size();
        send(8'h40); send(8'h41); send(8'h42); send(8'h43);
        i_valid = 1'b0;
        repeat (2) tick();
        i_flush = 1'b1;
        i_valid = 1'b1;
        i_data  = 8'h55;
        @(negedge clk);
        chk("t5_flush_ready", o_ready, 0);
        chk("t5_flush_dp_en", o_dp_en, 0);
        tick();
        i_flush = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t5_busy", o_busy, 1);
            chk("t5_valid", o_valid, 0);
            tick();
        end
        @(negedge clk);
        chk("t5_idle_busy", o_busy, 0);
        chk("t5_idle_ready", o_ready, 1);
        repeat (8) tick();
        chk("t5_no_results", got_q.size(), base);

        // 5b: a second flush restarts the drain counter.
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!o_busy) break;
            n++;
            tick();
        end
        chk("t5b_busy_len", n, 4);
        tick();

        // 6: reset with three ops in flight.
        i_ready = 1'b1;
        base = got_q.size();
        send(8'h60); send(8'h61); send(8'h62);
        i_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_valid", o_valid, 0);
        chk("t6_busy", o_busy, 0);
        chk("t6_dp_en", o_dp_en, 0);
        chk("t6_data", o_data, 0);
        chk("t6_ready", o_ready, 1);
        repeat (10) tick();
        chk("t6_no_stale", got_q.size(), base);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
